// File: rtl/vend_disp_pkg.sv
// vend_disp_pkg: shared source codes, FSM states and saturation helper for the display controller
package vend_disp_pkg;
   localparam int DISP_MAX = 99;
   localparam logic [1:0] SRC_CREDIT = 2'd0;
   localparam logic [1:0] SRC_PRICE  = 2'd1;
   localparam logic [1:0] SRC_CHANGE = 2'd2;
   typedef enum logic [1:0] {
      S_CREDIT = 2'd0,
      S_PRICE  = 2'd1,
      S_CHANGE = 2'd2
   } state_t;
   function automatic logic [6:0] sat(input logic [6:0] x, input logic [6:0] mx);
      return (x > mx) ? mx : x;
   endfunction
endpackage

// File: rtl/digit_scanner.sv
// digit_scanner: prescaled rotating active-low one-hot digit enable
module digit_scanner #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] an
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    an_q, an_d;
   logic          wrap;
   // prescaler wraps at SCAN_DIV-1 and rotates the enable left on wrap
   always_comb begin
      wrap  = cnt_q == CW'(SCAN_DIV - 1);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      an_d  = wrap ? {an_q[2:0], an_q[3]} : an_q;
   end
   // state registers, active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         an_q  <= 4'b1110;
      end else begin
         cnt_q <= cnt_d;
         an_q  <= an_d;
      end
   end
   assign an = an_q;
endmodule

// File: rtl/vend_display_ctrl.sv
// vend_display_ctrl: arbitrates credit/price/change onto the display bus with timed message hold
module vend_display_ctrl
   import vend_disp_pkg::*;
#(
   parameter int HOLD_CYC = 100000000,
   parameter int SCAN_DIV = 50000,
   parameter int SAT_MAX  = DISP_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] credit,
   input  logic [6:0] price,
   input  logic       price_req,
   input  logic [6:0] change,
   input  logic       change_req,
   output logic [6:0] value,
   output logic [1:0] src,
   output logic       busy,
   output logic [3:0] an
);
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [6:0] MX = 7'(SAT_MAX);
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [6:0]    prc_q, prc_d, chg_q, chg_d, value_q, value_d;
   logic          prc_pend_q, prc_pend_d, chg_pend_q, chg_pend_d;
   logic [1:0]    src_q, src_d;
   logic          busy_q, busy_d;
   logic          pc, pp, done, restart;
   // requests are folded into the same-cycle decision so a pulse is visible one edge later
   always_comb begin
      pc      = chg_pend_q | change_req;
      pp      = prc_pend_q | price_req;
      done    = hold_q == HW'(HOLD_CYC - 1);
      prc_d   = price_req ? sat(price, MX) : prc_q;
      chg_d   = change_req ? sat(change, MX) : chg_q;
      state_d = state_q;
      restart = 1'b0;
      case (state_q)
         S_CREDIT: state_d = pc ? S_CHANGE : pp ? S_PRICE : S_CREDIT;
         S_PRICE: begin
            restart = price_req & ~pc;
            state_d = pc ? S_CHANGE : price_req ? S_PRICE : done ? S_CREDIT : S_PRICE;
         end
         S_CHANGE: begin
            restart = change_req;
            state_d = change_req ? S_CHANGE : done ? (pp ? S_PRICE : S_CREDIT) : S_CHANGE;
         end
         default: state_d = S_CREDIT;
      endcase
      hold_d     = (state_d == S_CREDIT || state_d != state_q || restart) ? '0 : hold_q + 1'b1;
      chg_pend_d = pc & (state_d != S_CHANGE);
      prc_pend_d = pp & (state_d != S_PRICE);
      value_d    = (state_d == S_CHANGE) ? chg_d : (state_d == S_PRICE) ? prc_d : sat(credit, MX);
      src_d      = (state_d == S_CHANGE) ? SRC_CHANGE : (state_d == S_PRICE) ? SRC_PRICE : SRC_CREDIT;
      busy_d     = state_d != S_CREDIT;
   end
   // state, latched data and registered outputs, active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_CREDIT;
         hold_q     <= '0;
         prc_q      <= '0;
         chg_q      <= '0;
         prc_pend_q <= 1'b0;
         chg_pend_q <= 1'b0;
         value_q    <= '0;
         src_q      <= SRC_CREDIT;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         prc_q      <= prc_d;
         chg_q      <= chg_d;
         prc_pend_q <= prc_pend_d;
         chg_pend_q <= chg_pend_d;
         value_q    <= value_d;
         src_q      <= src_d;
         busy_q     <= busy_d;
      end
   end
   assign value = value_q;
   assign src   = src_q;
   assign busy  = busy_q;
   digit_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk(clk),
      .rst(rst),
      .an (an)
   );
endmodule

// File: tb/tb_vend_display_ctrl.sv
// tb_vend_display_ctrl: directed vector and sequence checks for the display scheduler
module tb_vend_display_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] credit = '0, price = '0, change = '0;
   logic       price_req = 1'b0, change_req = 1'b0;
   logic [6:0] value;
   logic [1:0] src;
   logic       busy;
   logic [3:0] an;
   int total = 0, bad = 0;
   typedef struct {
      logic [6:0] cr;
      logic [6:0] pr;
      logic       pq;
      logic [6:0] ch;
      logic       cq;
      logic [6:0] ev;
      logic [1:0] es;
   } vec_t;
   vec_t vecs [7];
   vend_display_ctrl #(.HOLD_CYC(10), .SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .credit(credit), .price(price), .price_req(price_req),
      .change(change), .change_req(change_req), .value(value), .src(src), .busy(busy), .an(an)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic step(input logic [6:0] cr, input logic [6:0] pr, input logic pq,
                       input logic [6:0] ch, input logic cq);
      credit = cr; price = pr; price_req = pq; change = ch; change_req = cq;
      @(posedge clk);
      #1;
   endtask
   task automatic expv(input string nm, input logic [6:0] ev, input logic [1:0] es);
      chk({nm, ".value"}, {1'b0, value}, {1'b0, ev});
      chk({nm, ".src"}, {6'd0, src}, {6'd0, es});
      chk({nm, ".busy"}, {7'd0, busy}, {7'd0, es != 2'd0});
   endtask
   task automatic hold(input string nm, input int n, input logic [6:0] cr,
                       input logic [6:0] ev, input logic [1:0] es);
      for (int i = 0; i < n; i++) begin
         step(cr, 7'd0, 1'b0, 7'd0, 1'b0);
         expv(nm, ev, es);
      end
   endtask
   initial begin
      vecs[0] = '{7'd25,  7'd0,  1'b0, 7'd0, 1'b0, 7'd25, 2'd0};
      vecs[1] = '{7'd120, 7'd0,  1'b0, 7'd0, 1'b0, 7'd99, 2'd0};
      vecs[2] = '{7'd99,  7'd0,  1'b0, 7'd0, 1'b0, 7'd99, 2'd0};
      vecs[3] = '{7'd0,   7'd0,  1'b0, 7'd0, 1'b0, 7'd0,  2'd0};
      vecs[4] = '{7'd100, 7'd0,  1'b0, 7'd0, 1'b0, 7'd99, 2'd0};
      vecs[5] = '{7'd127, 7'd0,  1'b0, 7'd0, 1'b0, 7'd99, 2'd0};
      vecs[6] = '{7'd35,  7'd60, 1'b1, 7'd0, 1'b0, 7'd60, 2'd1};
      rst = 1'b0;
      repeat (3) step(7'd50, 7'd0, 1'b0, 7'd0, 1'b0);
      expv("reset", 7'd0, 2'd0);
      chk("reset.an", {4'd0, an}, 8'b0000_1110);
      rst = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step(7'd0, 7'd0, 1'b0, 7'd0, 1'b0);
         if (i == 1) expv("release", 7'd0, 2'd0);
         if (i == 3) chk("scan3", {4'd0, an}, 8'b0000_1110);
         if (i == 4) chk("scan4", {4'd0, an}, 8'b0000_1101);
         if (i == 8) chk("scan8", {4'd0, an}, 8'b0000_1011);
         if (i == 12) chk("scan12", {4'd0, an}, 8'b0000_0111);
         if (i == 16) chk("scan16", {4'd0, an}, 8'b0000_1110);
      end
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].cr, vecs[i].pr, vecs[i].pq, vecs[i].ch, vecs[i].cq);
         expv($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es);
      end
      hold("price_hold", 9, 7'd35, 7'd60, 2'd1);
      hold("price_end", 1, 7'd35, 7'd35, 2'd0);
      step(7'd35, 7'd60, 1'b1, 7'd0, 1'b0);
      expv("pre_price", 7'd60, 2'd1);
      hold("pre_price_hold", 3, 7'd35, 7'd60, 2'd1);
      step(7'd35, 7'd0, 1'b0, 7'd15, 1'b1);
      expv("pre_change", 7'd15, 2'd2);
      hold("pre_change_hold", 9, 7'd35, 7'd15, 2'd2);
      hold("pre_no_price", 3, 7'd35, 7'd35, 2'd0);
      step(7'd35, 7'd80, 1'b1, 7'd5, 1'b1);
      expv("sim_change", 7'd5, 2'd2);
      hold("sim_change_hold", 9, 7'd35, 7'd5, 2'd2);
      hold("sim_price", 10, 7'd35, 7'd80, 2'd1);
      hold("sim_end", 1, 7'd35, 7'd35, 2'd0);
      step(7'd35, 7'd0, 1'b0, 7'd7, 1'b1);
      expv("chg_first", 7'd7, 2'd2);
      hold("chg_first_hold", 2, 7'd35, 7'd7, 2'd2);
      step(7'd35, 7'd44, 1'b1, 7'd0, 1'b0);
      expv("no_preempt", 7'd7, 2'd2);
      hold("no_preempt_hold", 6, 7'd35, 7'd7, 2'd2);
      hold("late_price", 10, 7'd35, 7'd44, 2'd1);
      hold("late_end", 1, 7'd35, 7'd35, 2'd0);
      step(7'd35, 7'd0, 1'b0, 7'd10, 1'b1);
      expv("rereq_a", 7'd10, 2'd2);
      hold("rereq_a_hold", 5, 7'd35, 7'd10, 2'd2);
      step(7'd35, 7'd0, 1'b0, 7'd20, 1'b1);
      expv("rereq_b", 7'd20, 2'd2);
      hold("rereq_b_hold", 9, 7'd35, 7'd20, 2'd2);
      hold("rereq_end", 1, 7'd35, 7'd35, 2'd0);
      step(7'd35, 7'd80, 1'b1, 7'd5, 1'b1);
      expv("abort_pre", 7'd5, 2'd2);
      hold("abort_pre_hold", 3, 7'd35, 7'd5, 2'd2);
      rst = 1'b0;
      step(7'd35, 7'd0, 1'b0, 7'd0, 1'b0);
      expv("abort", 7'd0, 2'd0);
      chk("abort.an", {4'd0, an}, 8'b0000_1110);
      rst = 1'b1;
      hold("abort_lost", 12, 7'd35, 7'd35, 2'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
